// File: rtl/lut_ram_writer.sv
// rtl/lut_ram_writer.sv - streaming writer that fills a LUT region through a registered RAM write port
// Optional XOR checksum of the loaded words: define LUT_WRITER_CHECKSUM_EN.
module lut_ram_writer #(
    parameter int data_width = 8,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width:0]   length,
    input  logic                  abort,
    input  logic [data_width-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [addr_width-1:0] wr_addr,
    output logic [data_width-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [addr_width:0]   words_wr
`ifdef LUT_WRITER_CHECKSUM_EN
    ,
    output logic [data_width-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [addr_width-1:0] addr_one = 1;
    localparam logic [addr_width:0]   cnt_one  = 1;

    state_t                  state;
    state_t                  state_next;
    logic [addr_width-1:0]   addr_cnt;
    logic [addr_width:0]     remaining;
    logic                    xfer;

    assign xfer = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer && (remaining == cnt_one)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == LOAD);
        busy    = (state != IDLE);
    end

    // A word arriving together with abort is dropped, so abort takes priority over xfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            words_wr  <= '0;
            addr_cnt  <= '0;
            remaining <= '0;
`ifdef LUT_WRITER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            wr_en   <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        words_wr  <= '0;
                        addr_cnt  <= base_addr;
                        remaining <= length;
`ifdef LUT_WRITER_CHECKSUM_EN
                        checksum  <= '0;
`endif
                        if (length == '0) begin
                            done <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (xfer) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= addr_cnt;
                        wr_data   <= s_data;
                        addr_cnt  <= addr_cnt + addr_one;
                        remaining <= remaining - cnt_one;
                        words_wr  <= words_wr + cnt_one;
`ifdef LUT_WRITER_CHECKSUM_EN
                        checksum  <= checksum ^ s_data;
`endif
                    end
                end
                FLUSH: begin
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_ram_writer.sv
// tb/tb_lut_ram_writer.sv - directed self-checking bench for lut_ram_writer
module tb_lut_ram_writer;

    localparam int dw = 8;
    localparam int aw = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [aw-1:0] base_addr;
    logic [aw:0]   length;
    logic          abort;
    logic [dw-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          wr_en;
    logic [aw-1:0] wr_addr;
    logic [dw-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [aw:0]   words_wr;
`ifdef LUT_WRITER_CHECKSUM_EN
    logic [dw-1:0] checksum;
    logic [dw-1:0] cs_at_done;
`endif

    always #5 clk = ~clk;

    lut_ram_writer #(.data_width(dw), .addr_width(aw)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .words_wr  (words_wr)
`ifdef LUT_WRITER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor, sampled on the falling edge.
    logic [aw-1:0] q_addr[$];
    logic [dw-1:0] q_data[$];
    int cyc = 0, last_wr_cyc = -1, done_cyc = -1;
    int done_cnt = 0, abort_cnt = 0, both_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (wr_en === 1'b1) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            last_wr_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef LUT_WRITER_CHECKSUM_EN
            cs_at_done = checksum;
`endif
        end
        if (aborted === 1'b1) abort_cnt++;
        if (done === 1'b1 && aborted === 1'b1) both_cnt++;
    end

    task automatic clr();
        q_addr.delete();
        q_data.delete();
        done_cnt = 0;
        abort_cnt = 0;
        last_wr_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [aw-1:0] b, input logic [aw:0] l);
        base_addr = b;
        length = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [dw-1:0] d);
        s_data = d;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        s_valid = 1'b1;
        abort = 1'b0;
        base_addr = 8'h33;
        length = 9'd5;
        s_data = 8'h5A;
        step();
        step();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_words_wr", 32'(words_wr), 32'd0);
`ifdef LUT_WRITER_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 32'd0);
`endif
        check("rst_no_writes", 32'(q_addr.size()), 32'd0);
        start = 1'b0;
        s_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // basic back-to-back load
        clr();
        start_load(8'h10, 9'd4);
        check("basic_busy", 32'(busy), 32'd1);
        send(8'hA1);
        send(8'hB2);
        send(8'hC3);
        send(8'hD4);
        repeat (3) step();
        check("basic_nwr", 32'(q_addr.size()), 32'd4);
        if (q_addr.size() == 4) begin
            check("basic_a0", 32'(q_addr[0]), 32'h10);
            check("basic_a3", 32'(q_addr[3]), 32'h13);
            check("basic_d0", 32'(q_data[0]), 32'hA1);
            check("basic_d1", 32'(q_data[1]), 32'hB2);
            check("basic_d3", 32'(q_data[3]), 32'hD4);
        end
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);
        check("basic_words_wr", 32'(words_wr), 32'd4);
        check("basic_idle", 32'(busy), 32'd0);

        // wrap-around with gaps, plus s_valid in FLUSH
        clr();
        start_load(8'hFE, 9'd3);
        send(8'h01);
        step();
        send(8'h02);
        step();
        step();
        send(8'h03);
        s_data = 8'h77;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        repeat (3) step();
        check("wrap_nwr", 32'(q_addr.size()), 32'd3);
        if (q_addr.size() == 3) begin
            check("wrap_a0", 32'(q_addr[0]), 32'hFE);
            check("wrap_a1", 32'(q_addr[1]), 32'hFF);
            check("wrap_a2", 32'(q_addr[2]), 32'h00);
            check("wrap_d2", 32'(q_data[2]), 32'h03);
        end
        check("wrap_done_cnt", 32'(done_cnt), 32'd1);

        // abort after three words, coincident word is dropped
        clr();
        start_load(8'h00, 9'd8);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        s_data = 8'h99;
        s_valid = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        s_valid = 1'b0;
        check("abort_s_ready", 32'(s_ready), 32'd0);
        check("abort_pulse", 32'(aborted), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) step();
        check("abort_nwr", 32'(q_addr.size()), 32'd3);
        check("abort_words_wr", 32'(words_wr), 32'd3);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check("abort_cnt", 32'(abort_cnt), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        check("abort_idle_ign", 32'(abort_cnt), 32'd1);

        // zero-length load
        clr();
        start_load(8'h20, 9'd0);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        repeat (2) step();
        check("len0_done_cnt", 32'(done_cnt), 32'd1);
        check("len0_nwr", 32'(q_addr.size()), 32'd0);

        // full-depth load, with a start pulse during LOAD
        clr();
        start_load(8'h40, 9'h100);
        for (int i = 0; i < 256; i++) begin
            if (i == 5) begin
                start = 1'b1;
                base_addr = 8'h00;
                length = 9'd1;
            end
            send(8'(i));
            start = 1'b0;
        end
        repeat (3) step();
        check("full_nwr", 32'(q_addr.size()), 32'd256);
        if (q_addr.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                check("full_addr", 32'(q_addr[i]), 32'((i + 8'h40) & 8'hFF));
                check("full_data", 32'(q_data[i]), 32'(i));
            end
        end
        check("full_words_wr", 32'(words_wr), 32'd256);
        check("full_last_addr", 32'(wr_addr), 32'h3F);
        check("full_done_cnt", 32'(done_cnt), 32'd1);

`ifdef LUT_WRITER_CHECKSUM_EN
        clr();
        start_load(8'h80, 9'd3);
        send(8'h0F);
        send(8'hF0);
        send(8'h55);
        repeat (3) step();
        check("cs_done_cnt", 32'(done_cnt), 32'd1);
        check("cs_value", 32'(cs_at_done), 32'hAA);
        check("cs_hold", 32'(checksum), 32'hAA);
`endif

        check("done_aborted_excl", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
